uc_consome_rota: RTL
====================

Name: uc_consome_rota

Overview:
- Read-side control unit for the SmartCargo route RAM; counterpart of the insertion FSM that writes origin/destination stops into the same RAM.
- Polls the head entry (address 0), drives the target floor and motion requests, and holds the door open on arrival.
- After door completion, removes the served stop by shifting every later entry down one slot, which compacts the queue.
- Sits between the route RAM port mux, the position sensor and the door/motor controller.

Parameters:
- FLOOR_W, default 3: floor number width.
- ADDR_W, default 4: route RAM address width.
- DEPTH, default 16: route RAM entries; DEPTH <= 2**ADDR_W, DEPTH >= 2.
- DWELL_CYCLES, default 50: door hold time; used only with the optional feature.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- enable, in, 1: system running (iniciar).
- writer_req, in, 1: new-request edge seen by the insertion FSM this cycle.
- writer_busy, in, 1: insertion FSM is outside its idle state.
- floor_current, in, FLOOR_W: current car floor.
- floor_valid, in, 1: car is level and stopped at floor_current.
- door_done, in, 1: one-cycle pulse, door cycle complete.
- ram_rdata, in, FLOOR_W+1: RAM read data; MSB is the valid bit, low bits are the floor.
- ram_addr, out, ADDR_W: RAM address.
- ram_wdata, out, FLOOR_W+1: RAM write data.
- ram_we, out, 1: RAM write enable.
- target_floor, out, FLOOR_W: registered head floor.
- target_valid, out, 1: head entry is valid.
- move_up, out, 1: request upward motion.
- move_down, out, 1: request downward motion.
- door_open, out, 1: hold door open.
- served_pulse, out, 1: one cycle per removed stop.
- reader_busy, out, 1: this FSM owns the RAM port.
- Eatual_db, out, 4: state code, for debug.

Behaviour:
- Reset (asynchronous): state IDLE; target_floor=0; target_valid=0; idx=0; every combinational output 0.
- RAM is synchronous read: data appears one cycle after the address is driven.
- ram_addr is 0 in any state that does not specify it.
- ram_we is 1 only in SH_WR and CLR_LAST.

State machine:
- IDLE (0): if enable && !writer_busy && !writer_req, go to RD_HEAD; otherwise stay. The writer wins any simultaneous request.
- RD_HEAD (1): ram_addr=0; go to CHK_HEAD.
- CHK_HEAD (2): load target_floor from ram_rdata[FLOOR_W-1:0] and target_valid from the MSB.
  - If valid && floor_valid && floor_current==floor, go to DOOR.
  - Otherwise go to IDLE.
  - Net effect: the head is re-polled every 3 cycles while idle.
- DOOR (3): door_open=1. On door_done: served_pulse=1 in this same cycle, idx<=0, go to SH_RD. enable has no effect once in DOOR.
- SH_RD (4): ram_addr=idx+1; go to SH_WR.
- SH_WR (5): ram_addr=idx, ram_wdata=ram_rdata, ram_we=1.
  - If the rdata MSB is 0 (an invalid entry was copied), go to IDLE.
  - Else if idx+1==DEPTH-1, go to CLR_LAST.
  - Else idx<=idx+1 and go to SH_RD.
- CLR_LAST (6): ram_addr=DEPTH-1, ram_wdata=0, ram_we=1; go to IDLE.

Outputs:
- reader_busy = (state != IDLE). The insertion FSM must not leave its idle state while reader_busy is high.
- move_up = target_valid && state!=DOOR && floor_current<target_floor.
- move_down = target_valid && state!=DOOR && floor_current>target_floor.
- move_up and move_down are never both 1. Both are 0 when floors are equal or the queue is empty.

Timing and boundaries:
- Compaction of a queue holding k valid entries (k<DEPTH) takes 2k cycles.
- A full queue takes 2(DEPTH-1)+1 cycles and ends with the last slot cleared.
- Empty head: target_valid=0, no door, no shift.
- A single-entry queue takes one copy iteration (slot1 invalid → slot0), then IDLE.
- Reset during a shift leaves the RAM partially compacted; the top level clears the RAM on reset.
- floor_valid dropping during DOOR is ignored.

Optional Feature:
- Macro: UC_CONSOME_DWELL_TIMER_EN.
- Defined:
  - An internal counter of width $clog2(DWELL_CYCLES+1) clears on entry to DOOR and increments every DOOR cycle.
  - DOOR exits when the count reaches DWELL_CYCLES-1, so door_open is high for exactly DWELL_CYCLES cycles.
  - The door_done input is ignored.
- Not defined: no counter exists; DOOR exits only on door_done.

Decomposition:
- Shared package smartcargo_pkg:
  - FLOOR_W and ADDR_W defaults.
  - Entry layout (valid bit position, floor field).
  - State encodings for this FSM, for Eatual_db decoding.
  - EMPTY_ENTRY constant (all zeros).
- One natural sub-module, route_shift_dp: idx counter, address mux and write-data path. The FSM stays in uc_consome_rota, matching the existing uc/datapath split.

Test Plan (DEPTH=8 unless stated):
1. RAM = {valid 3, valid 5, rest empty}, floor_current=1, floor_valid=0 → within 3 cycles target_floor=3, target_valid=1, move_up=1, move_down=0; no RAM writes.
2. Same RAM, floor_current=3, floor_valid=1 → DOOR with door_open=1; door_done pulse gives served_pulse=1 once. RAM becomes {5, empty, …} with exactly 2 writes over 4 cycles. Next poll gives target_floor=5.
3. Full RAM {1,2,…,8}, arrive at floor 1 → 7 copy writes plus a CLR_LAST write of 0 to address 7 (15 cycles after door_done). RAM ends {2..8, empty}.
4. Empty RAM → target_valid=0, move_up=move_down=0, door_open never asserts.
5. writer_busy=1 held while in IDLE → FSM stays in IDLE and reader_busy=0. writer_req and enable pulsed in the same cycle → no RD_HEAD that cycle.
6. Reset asserted during SH_WR → immediate IDLE with ram_we=0 and all outputs 0. With UC_CONSOME_DWELL_TIMER_EN and DWELL_CYCLES=4 → door_open high for exactly 4 cycles with door_done tied 0.

Source files
------------

// File: rtl/smartcargo_pkg.sv
// Shared SmartCargo definitions: default widths, route entry layout and the
// read-side FSM state codes reported on Eatual_db.
package smartcargo_pkg;

  localparam int FLOOR_W_DEF = 3;
  localparam int ADDR_W_DEF  = 4;

  // Route entry: {valid, floor}; the valid bit sits just above the floor field.
  localparam int ENTRY_W_DEF   = FLOOR_W_DEF + 1;
  localparam int ENTRY_VLD_BIT = FLOOR_W_DEF;

  localparam logic [ENTRY_W_DEF-1:0] EMPTY_ENTRY = '0;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_HEAD  = 4'd1,
    CHK_HEAD = 4'd2,
    DOOR     = 4'd3,
    SH_RD    = 4'd4,
    SH_WR    = 4'd5,
    CLR_LAST = 4'd6
  } rota_state_e;

  typedef enum logic [1:0] {
    ADDR_HEAD = 2'd0,
    ADDR_NEXT = 2'd1,
    ADDR_IDX  = 2'd2,
    ADDR_LAST = 2'd3
  } rota_addr_sel_e;

endpackage

// File: rtl/route_shift_dp.sv
// Compaction datapath for the route RAM reader: slot index counter, RAM
// address mux and write-data path (copy of the read entry or an empty entry).
module route_shift_dp
  import smartcargo_pkg::*;
#(
  parameter int FLOOR_W = FLOOR_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               idx_clr,
  input  logic               idx_inc,
  input  logic [1:0]         addr_sel,
  input  logic               wdata_copy,
  input  logic [FLOOR_W:0]   ram_rdata,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [FLOOR_W:0]   ram_wdata,
  output logic               idx_at_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [ADDR_W-1:0] idx_next;

  assign idx_next = idx_q + 1'b1;

  always_comb begin
    idx_d = idx_q;
    if (idx_clr) begin
      idx_d = '0;
    end else if (idx_inc) begin
      idx_d = idx_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  always_comb begin
    ram_addr = '0;
    case (rota_addr_sel_e'(addr_sel))
      ADDR_HEAD: ram_addr = '0;
      ADDR_NEXT: ram_addr = idx_next;
      ADDR_IDX:  ram_addr = idx_q;
      ADDR_LAST: ram_addr = LAST_ADDR;
      default:   ram_addr = '0;
    endcase
  end

  // Outside the copy step the write bus idles at the empty entry.
  assign ram_wdata   = wdata_copy ? ram_rdata : '0;
  assign idx_at_last = (idx_next == LAST_ADDR);

endmodule

// File: rtl/uc_consome_rota.sv
// Read-side control unit for the SmartCargo route RAM: polls the head stop,
// drives motion/door requests and compacts the queue after a stop is served.
// Optional fixed door dwell timer: define UC_CONSOME_DWELL_TIMER_EN.
module uc_consome_rota
  import smartcargo_pkg::*;
#(
  parameter int FLOOR_W      = FLOOR_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DEPTH        = 16,
  parameter int DWELL_CYCLES = 50
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               writer_req,
  input  logic               writer_busy,
  input  logic [FLOOR_W-1:0] floor_current,
  input  logic               floor_valid,
  input  logic               door_done,
  input  logic [FLOOR_W:0]   ram_rdata,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [FLOOR_W:0]   ram_wdata,
  output logic               ram_we,
  output logic [FLOOR_W-1:0] target_floor,
  output logic               target_valid,
  output logic               move_up,
  output logic               move_down,
  output logic               door_open,
  output logic               served_pulse,
  output logic               reader_busy,
  output logic [3:0]         Eatual_db
);

  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("uc_consome_rota: DEPTH must be in [2, 2**ADDR_W]");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("uc_consome_rota: DWELL_CYCLES must be at least 1");
  end

  rota_state_e        state_q, state_d;
  logic [FLOOR_W-1:0] target_floor_q, target_floor_d;
  logic               target_valid_q, target_valid_d;

  logic               head_vld;
  logic [FLOOR_W-1:0] head_floor;
  logic               door_exit;
  logic               idx_clr;
  logic               idx_inc;
  logic               wdata_copy;
  logic               idx_at_last;
  rota_addr_sel_e     addr_sel;

  assign head_vld   = ram_rdata[FLOOR_W];
  assign head_floor = ram_rdata[FLOOR_W-1:0];

`ifdef UC_CONSOME_DWELL_TIMER_EN
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);

  logic [DW_W-1:0] dwell_cnt_q, dwell_cnt_d;

  // Held at zero outside DOOR, so every door visit starts counting from 0.
  assign dwell_cnt_d = (state_q == DOOR) ? dwell_cnt_q + 1'b1 : '0;
  assign door_exit   = (dwell_cnt_q == DW_W'(DWELL_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dwell_cnt_q <= '0;
    end else begin
      dwell_cnt_q <= dwell_cnt_d;
    end
  end
`else
  assign door_exit = door_done;
`endif

  always_comb begin
    state_d        = state_q;
    target_floor_d = target_floor_q;
    target_valid_d = target_valid_q;
    ram_we         = 1'b0;
    door_open      = 1'b0;
    served_pulse   = 1'b0;
    idx_clr        = 1'b0;
    idx_inc        = 1'b0;
    wdata_copy     = 1'b0;
    addr_sel       = ADDR_HEAD;
    case (state_q)
      IDLE: begin
        // The insertion FSM has priority over a same-cycle poll.
        if (enable && !writer_busy && !writer_req) begin
          state_d = RD_HEAD;
        end
      end
      RD_HEAD: begin
        state_d = CHK_HEAD;
      end
      CHK_HEAD: begin
        target_floor_d = head_floor;
        target_valid_d = head_vld;
        if (head_vld && floor_valid && (floor_current == head_floor)) begin
          state_d = DOOR;
        end else begin
          state_d = IDLE;
        end
      end
      DOOR: begin
        door_open = 1'b1;
        if (door_exit) begin
          served_pulse = 1'b1;
          idx_clr      = 1'b1;
          state_d      = SH_RD;
        end
      end
      SH_RD: begin
        addr_sel = ADDR_NEXT;
        state_d  = SH_WR;
      end
      SH_WR: begin
        // ram_rdata holds slot idx+1, read during SH_RD.
        addr_sel   = ADDR_IDX;
        wdata_copy = 1'b1;
        ram_we     = 1'b1;
        if (!head_vld) begin
          state_d = IDLE;
        end else if (idx_at_last) begin
          state_d = CLR_LAST;
        end else begin
          idx_inc = 1'b1;
          state_d = SH_RD;
        end
      end
      CLR_LAST: begin
        addr_sel = ADDR_LAST;
        ram_we   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      target_floor_q <= '0;
      target_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_floor_q <= target_floor_d;
      target_valid_q <= target_valid_d;
    end
  end

  route_shift_dp #(
    .FLOOR_W (FLOOR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_dp (
    .clock       (clock),
    .reset       (reset),
    .idx_clr     (idx_clr),
    .idx_inc     (idx_inc),
    .addr_sel    (addr_sel),
    .wdata_copy  (wdata_copy),
    .ram_rdata   (ram_rdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .idx_at_last (idx_at_last)
  );

  assign target_floor = target_floor_q;
  assign target_valid = target_valid_q;
  assign reader_busy  = (state_q != IDLE);
  assign Eatual_db    = state_q;
  assign move_up      = target_valid_q && (state_q != DOOR) && (floor_current < target_floor_q);
  assign move_down    = target_valid_q && (state_q != DOOR) && (floor_current > target_floor_q);

endmodule
